// File: rtl/dekatron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dekatron_pkg
// Description : Shared types and helpers for the dekatron stepping driver.
//               - DEKATRON_WIDTH : number of glow positions (10)
//               - stepState_t    : stepper FSM states
//               - onehot10       : binary digit -> one-hot position
//               - rotUp10/rotDown10 : one-position rotation with 9<->0 wrap
// Revision    : 1.0  initial release
// ============================================================================
package dekatron_pkg;

  localparam int DEKATRON_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    DONE = 2'd3
  } stepState_t;

  // Out-of-range digits map to all-zero so the caller can reject them.
  function automatic logic [DEKATRON_WIDTH-1:0] onehot10(input logic [3:0] digit);
    logic [DEKATRON_WIDTH-1:0] result;
    result = '0;
    if (digit <= 4'd9) begin
      result[digit] = 1'b1;
    end
    return result;
  endfunction

  function automatic logic [DEKATRON_WIDTH-1:0] rotUp10(input logic [DEKATRON_WIDTH-1:0] pos);
    return {pos[DEKATRON_WIDTH-2:0], pos[DEKATRON_WIDTH-1]};
  endfunction

  function automatic logic [DEKATRON_WIDTH-1:0] rotDown10(input logic [DEKATRON_WIDTH-1:0] pos);
    return {pos[0], pos[DEKATRON_WIDTH-1:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dekatron_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : dekatron_phase_timer
// Description : Loadable down-counter timing one guide phase.
//   Ports:
//     Clk       in   system clock
//     Rst_n     in   asynchronous active-low reset
//     Load      in   reload the counter with PULSE_CYCLES-1
//     TermCount out  counter has reached zero (last cycle of the phase)
// Revision    : 1.0  initial release
// ============================================================================
module dekatron_phase_timer #(
  parameter int PULSE_CYCLES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Load,
  output logic TermCount
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  // Loaded on the edge that enters a phase, so the phase lasts
  // PULSE_CYCLES cycles including the one where the count reads zero.
  localparam logic [CW-1:0] c_loadValue = CW'(PULSE_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_count <= '0;
    end else if (Load) begin
      r_count <= c_loadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign TermCount = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/dekatron_stepper.sv
`default_nettype none
// ============================================================================
// Module      : dekatron_stepper
// Description : Stepping driver for one 10-position dekatron digit.
//   Ports:
//     Clk      in   system clock
//     Rst_n    in   asynchronous active-low reset
//     Request  in   start an operation (sampled while Busy=0)
//     Dec      in   1 = decrement, 0 = increment
//     Set      in   load takes priority over step
//     In[3:0]  in   load value 0..9 (larger values ignored)
//     Out[9:0] out  registered one-hot glow position
//     Guide[1:0] out guide-electrode drive (bit0 = guide-1, bit1 = guide-2)
//     Busy     out  step in progress
//     Ready    out  one-cycle completion pulse
//     Carry    out  one-cycle wrap pulse, coincident with Ready
// Revision    : 1.0  initial release
// ============================================================================
module dekatron_stepper
  import dekatron_pkg::*;
#(
  parameter int PULSE_CYCLES = 2
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Request,
  input  logic                      Dec,
  input  logic                      Set,
  input  logic [3:0]                In,
  output logic [DEKATRON_WIDTH-1:0] Out,
  output logic [1:0]                Guide,
  output logic                      Busy,
  output logic                      Ready,
  output logic                      Carry
);

  stepState_t                r_state;
  stepState_t                w_stateNext;
  logic                      r_dec;
  logic                      w_decNext;
  logic [DEKATRON_WIDTH-1:0] r_out;
  logic [DEKATRON_WIDTH-1:0] w_outNext;
  logic [1:0]                r_guide;
  logic [1:0]                w_guideNext;
  logic                      r_busy;
  logic                      r_ready;
  logic                      w_readyNext;
  logic                      r_carry;
  logic                      w_carryNext;
  logic                      w_timerLoad;
  logic                      w_termCount;

  dekatron_phase_timer #(
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_phaseTimer (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Load      (w_timerLoad),
    .TermCount (w_termCount)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
      r_dec   <= 1'b0;
      r_out   <= onehot10(4'd0);
      r_guide <= 2'b00;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_dec   <= w_decNext;
      r_out   <= w_outNext;
      r_guide <= w_guideNext;
      r_busy  <= (w_stateNext != IDLE);
      r_ready <= w_readyNext;
      r_carry <= w_carryNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_decNext   = r_dec;
    w_outNext   = r_out;
    w_readyNext = 1'b0;
    w_carryNext = 1'b0;
    w_timerLoad = 1'b0;
    w_guideNext = 2'b00;

    unique case (r_state)
      IDLE: begin
        if (Request) begin
          if (Set) begin
            if (In <= 4'd9) begin
              w_outNext = onehot10(In);
            end
            w_readyNext = 1'b1;
          end else begin
            w_stateNext = PH1;
            w_decNext   = Dec;
            w_timerLoad = 1'b1;
          end
        end
      end
      PH1: begin
        if (w_termCount) begin
          w_stateNext = PH2;
          w_timerLoad = 1'b1;
        end
      end
      PH2: begin
        if (w_termCount) begin
          w_stateNext = DONE;
          w_readyNext = 1'b1;
          if (r_dec) begin
            w_outNext   = rotDown10(r_out);
            w_carryNext = r_out[0];
          end else begin
            w_outNext   = rotUp10(r_out);
            w_carryNext = r_out[DEKATRON_WIDTH-1];
          end
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    // Guide is registered from the upcoming state so it lines up with the
    // phase it belongs to; the two phases swap which guide fires by direction.
    case (w_stateNext)
      PH1:     w_guideNext = w_decNext ? 2'b10 : 2'b01;
      PH2:     w_guideNext = w_decNext ? 2'b01 : 2'b10;
      default: w_guideNext = 2'b00;
    endcase
  end

  assign Out   = r_out;
  assign Guide = r_guide;
  assign Busy  = r_busy;
  assign Ready = r_ready;
  assign Carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_dekatron_stepper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dekatron_stepper
// Description : Self-checking bench for dekatron_stepper. The glow position
//               is modelled as an integer digit 0..9; expected outputs are
//               derived from that digit and the operation timing rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dekatron_stepper;

  localparam int P = 2;

  logic       Clk;
  logic       Rst_n;
  logic       Request;
  logic       Dec;
  logic       Set;
  logic [3:0] In;
  logic [9:0] Out;
  logic [1:0] Guide;
  logic       Busy;
  logic       Ready;
  logic       Carry;

  int total;
  int bad;
  int digit;

  dekatron_stepper #(
    .PULSE_CYCLES (P)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Request (Request),
    .Dec     (Dec),
    .Set     (Set),
    .In      (In),
    .Out     (Out),
    .Guide   (Guide),
    .Busy    (Busy),
    .Ready   (Ready),
    .Carry   (Carry)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pos(input int d);
    return 32'd1 << d;
  endfunction

  // Entered and left at a falling edge. Load lasts one cycle; Request is
  // left as driven so successive calls form back-to-back loads.
  task automatic doLoad(input logic [3:0] v);
    Request = 1'b1; Set = 1'b1; In = v; Dec = $urandom_range(0, 1);
    @(posedge Clk); @(negedge Clk);
    if (v <= 4'd9) digit = v;
    chk("load_out",   Out,   pos(digit));
    chk("load_ready", Ready, 1);
    chk("load_carry", Carry, 0);
    chk("load_guide", Guide, 0);
    chk("load_busy",  Busy,  0);
  endtask

  // Full step. Disturbs Request/Dec/Set/In during the first phase to show
  // that they are ignored while busy.
  task automatic doStep(input logic d);
    int  nd;
    logic cy;
    logic [1:0] g;
    Request = 1'b1; Set = 1'b0; Dec = d; In = $urandom_range(0, 15);
    @(posedge Clk); @(negedge Clk);
    nd = d ? (digit + 9) % 10 : (digit + 1) % 10;
    cy = d ? (digit == 0) : (digit == 9);
    for (int c = 1; c <= 2 * P + 1; c++) begin
      if (c == 1) begin
        Request = 1'b1; Set = $urandom_range(0, 1); Dec = ~d;
      end else begin
        Request = 1'b0;
      end
      if (c <= P)          g = d ? 2'b10 : 2'b01;
      else if (c <= 2 * P) g = d ? 2'b01 : 2'b10;
      else                 g = 2'b00;
      chk("step_guide", Guide, g);
      chk("step_busy",  Busy,  1);
      chk("step_ready", Ready, c == 2 * P + 1);
      chk("step_carry", Carry, (c == 2 * P + 1) && cy);
      chk("step_out",   Out,   pos(c == 2 * P + 1 ? nd : digit));
      @(negedge Clk);
    end
    digit = nd;
    chk("idle_busy",  Busy,  0);
    chk("idle_ready", Ready, 0);
    chk("idle_guide", Guide, 0);
  endtask

  initial begin
    total = 0; bad = 0; digit = 0;
    Rst_n = 1'b0; Request = 1'b0; Dec = 1'b0; Set = 1'b0; In = 4'd0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rst_out",   Out,   10'h001);
    chk("rst_guide", Guide, 0);
    chk("rst_busy",  Busy,  0);
    chk("rst_ready", Ready, 0);
    chk("rst_carry", Carry, 0);

    // Increment from 0, load 9 then wrap up, decrement wrap from 0.
    doStep(1'b0);
    chk("inc_from0", Out, 10'h002);
    doLoad(4'd9);
    Request = 1'b0;
    doStep(1'b0);
    chk("inc_wrap", Out, 10'h001);
    doStep(1'b1);
    chk("dec_wrap", Out, 10'h200);

    // Back-to-back loads, the second out of range.
    doLoad(4'd7);
    chk("load7", Out, 10'h080);
    doLoad(4'd12);
    chk("load12", Out, 10'h080);
    Request = 1'b0; Set = 1'b0;
    @(negedge Clk);
    chk("load_ready_drop", Ready, 0);

    // Randomized mix of loads and steps against the digit model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          doLoad(4'($urandom_range(0, 15)));
          if ($urandom_range(0, 1) == 1) doLoad(4'($urandom_range(0, 15)));
          Request = 1'b0; Set = 1'b0;
          @(negedge Clk);
        end
        1: doStep(1'b0);
        default: doStep(1'b1);
      endcase
    end

    // Reset asserted in the middle of the second phase.
    doLoad(4'd5);
    Request = 1'b0; Set = 1'b0;
    @(negedge Clk);
    Request = 1'b1; Dec = 1'b0;
    @(posedge Clk); @(negedge Clk);
    Request = 1'b0;
    repeat (P) @(negedge Clk);
    chk("pre_rst_guide", Guide, 2'b10);
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_guide", Guide, 0);
    chk("arst_out",   Out,   10'h001);
    chk("arst_busy",  Busy,  0);
    chk("arst_ready", Ready, 0);
    repeat (2 * P) begin
      @(negedge Clk);
      chk("arst_no_ready", Ready, 0);
      chk("arst_no_carry", Carry, 0);
    end
    Rst_n = 1'b1;
    digit = 0;
    @(negedge Clk);
    chk("post_rst_out", Out, 10'h001);
    doStep(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dekatron_stepper.md
# dekatron_stepper

Stepping driver for one 10-position dekatron digit. It accepts increment, decrement and load requests, generates the two-phase guide-electrode pulse sequence that moves the glow, and maintains the registered one-hot glow position. On wrap-around it emits a carry/borrow pulse to the next digit. The one-hot position output feeds the carry-detection logic and the digit display.

## Interface
Parameters:
- PULSE_CYCLES, default 2: clock cycles per guide phase; must be ≥1.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst_n  in  1  reset; asynchronous, active-low.
- Request  in  1  start an operation; sampled only while Busy=0.
- Dec  in  1  step direction qualifier: 1 = decrement, 0 = increment.
- Set  in  1  load qualifier; when 1, a load takes priority over a step.
- In  in  4  load value, binary 0–9.
- Out  out  10  one-hot glow position; bit k means digit k.
- Guide  out  2  guide-electrode drive: Guide[0] is guide-1, Guide[1] is guide-2; active high.
- Busy  out  1  high while a step is in progress.
- Ready  out  1  one-cycle pulse when an operation completes.
- Carry  out  1  one-cycle pulse, coincident with Ready, on a 9→0 increment or a 0→9 decrement.

## Operation
- FSM states: IDLE, PH1, PH2, DONE.
- IDLE with Request & Set:
  - The FSM stays in IDLE.
  - If In ≤ 9, Out loads onehot(In) at the next edge.
  - If In > 9, Out is unchanged.
  - In both cases Ready pulses, Carry=0, and no guide pulse is issued.
- IDLE with Request & !Set:
  - The FSM goes to PH1 and latches Dec; Dec is ignored after that.
- PH1:
  - Increment drives Guide=01; decrement drives Guide=10.
  - The phase counter runs PULSE_CYCLES cycles, then the FSM goes to PH2.
- PH2:
  - Increment drives Guide=10; decrement drives Guide=01.
  - The phase runs PULSE_CYCLES cycles, then the FSM goes to DONE.
- DONE:
  - Guide=00.
  - Out rotates: left by 1 for increment, right by 1 for decrement, wrapping bit9↔bit0.
  - Ready=1, and Carry=1 if the step wrapped.
  - The FSM goes to IDLE.
- Guide is never 11. Guide is 00 in IDLE and DONE.
- Request while Busy=1 is ignored. It is not queued.
- Busy=1 in PH1, PH2 and DONE.

## Timing
- Request sampled at edge 0 (step case):
  - PH1 Guide active during cycles 1..P.
  - PH2 Guide active during cycles P+1..2P.
  - DONE in cycle 2P+1: the new Out, Ready and Carry are all visible.
  - Busy falls at cycle 2P+2, where a new Request is accepted. The minimum step period is 2P+2 cycles.
- Load latency: Out, Ready and Carry=0 are valid in cycle 1. Back-to-back loads are accepted every cycle.
- Reset values: Out=10'b0000000001, Guide=00, Busy=0, Ready=0, Carry=0, state IDLE, phase counter 0.
- Reset mid-operation: Guide goes to 00 immediately (asynchronously), the step is discarded, and Out returns to digit 0. No Ready or Carry pulse is issued.
- Phase counter width is $clog2(PULSE_CYCLES+1). It reloads on every phase entry.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package dekatron_pkg contains:
  - DEKATRON_WIDTH = 10.
  - typedef enum for stepper states {IDLE, PH1, PH2, DONE}.
  - function onehot10(logic [3:0]) returning 10 bits, all-zero for inputs >9.
  - rotate-up and rotate-down functions for the 10-bit one-hot vector.
- One sub-module, dekatron_phase_timer:
  - Loadable down-counter with a terminal-count output, parameterised by PULSE_CYCLES.
  - The FSM and position register stay in dekatron_stepper.

## Test plan
All scenarios use PULSE_CYCLES=2.
- Reset:
  - Stimulus: release Rst_n.
  - Required: Out=0x001, Guide=00, Busy=0, Ready=0, Carry=0.
- Increment from 0:
  - Stimulus: Request=1, Dec=0 at edge 0.
  - Required: Guide=01 in cycles 1–2, Guide=10 in cycles 3–4, Out=0x002 with Ready=1 and Carry=0 in cycle 5, Busy=0 in cycle 6.
- Increment wrap:
  - Stimulus: load 9, then increment.
  - Required: Out=0x001 and Carry=1 in the DONE cycle.
- Decrement wrap:
  - Stimulus: Request=1, Dec=1 from digit 0.
  - Required: Guide=10 in cycles 1–2, Guide=01 in cycles 3–4, Out=0x200 with Carry=1 in cycle 5.
- Loads:
  - Stimulus: Set with In=7, then Set with In=12.
  - Required: Out=0x080 with Ready in the next cycle; In=12 leaves Out=0x080 with Ready=1, and Guide stays 00 throughout.
- Busy and reset:
  - Stimulus: Request pulsed during PH1, then Rst_n asserted during PH2.
  - Required: the PH1 Request has no effect; on reset Guide=00 immediately, Out=0x001, and no Ready pulse.
